// File: rtl/jtag_master_if.sv
// jtag_master_if: command/response handshake bundle between a JTAG command source and jtag_master.
// master = command source side, slave = jtag_master side.
interface jtag_master_if #(
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [LEN_W-1:0]    cmd_len;
    logic [MAX_BITS-1:0] cmd_tms;
    logic [MAX_BITS-1:0] cmd_tdi;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [MAX_BITS-1:0] rsp_tdo;

    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );
endinterface

// File: rtl/jtag_master.sv
// jtag_master: turns command words into TCK/TMS/TDI bit sequences and returns captured TDO bits.
// Define JTAG_MASTER_TRST_EN to add cmd_trst/TRSTn and a TRST pulse command.
module jtag_master #(
    parameter int CLK_DIV  = 2,
    parameter int MAX_BITS = 32,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic         CLK,
    input  logic         RSTn,
    jtag_master_if.slave bus,
`ifdef JTAG_MASTER_TRST_EN
    input  logic         cmd_trst,
    output logic         TRSTn,
`endif
    output logic         busy,
    output logic         TCK,
    output logic         TMS,
    output logic         TDI,
    input  logic         TDO
);
    localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

`ifdef JTAG_MASTER_TRST_EN
    localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(2 * CLK_DIV - 1);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, DONE, TRST} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_next;
    logic [LEN_W-1:0]    len_q, len_d, len_in;
    logic [MAX_BITS-1:0] tms_q, tms_d, tdi_q, tdi_d, cap_q, cap_d;
    logic [MAX_BITS-1:0] rsp_tdo_q, rsp_tdo_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                tck_q, tck_d, tms_pin_q, tms_pin_d, tdi_pin_q, tdi_pin_d;
    logic                cmd_ready;
`ifdef JTAG_MASTER_TRST_EN
    logic                trstn_q, trstn_d;
    assign TRSTn = trstn_q;
`endif

    assign cmd_ready     = (state_q == IDLE) && !rsp_valid_q;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tdo   = rsp_tdo_q;
    assign busy          = (state_q != IDLE);
    assign TCK           = tck_q;
    assign TMS           = tms_pin_q;
    assign TDI           = tdi_pin_q;
    assign len_in        = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
    assign idx_next      = idx_q + 1'b1;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            tms_q       <= '0;
            tdi_q       <= '0;
            cap_q       <= '0;
            rsp_tdo_q   <= '0;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tms_pin_q   <= 1'b1;
            tdi_pin_q   <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
            trstn_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            cap_q       <= cap_d;
            rsp_tdo_q   <= rsp_tdo_d;
            rsp_valid_q <= rsp_valid_d;
            tck_q       <= tck_d;
            tms_pin_q   <= tms_pin_d;
            tdi_pin_q   <= tdi_pin_d;
`ifdef JTAG_MASTER_TRST_EN
            trstn_q     <= trstn_d;
`endif
        end
    end

    // TDO is captured on the edge that raises TCK; TMS/TDI only move on the edge that lowers it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        cap_d       = cap_q;
        rsp_tdo_d   = rsp_tdo_q;
        rsp_valid_d = rsp_valid_q;
        tck_d       = tck_q;
        tms_pin_d   = tms_pin_q;
        tdi_pin_d   = tdi_pin_q;
`ifdef JTAG_MASTER_TRST_EN
        trstn_d     = trstn_q;
`endif
        case (state_q)
            IDLE: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (bus.cmd_valid && cmd_ready) begin
                    len_d = len_in;
                    tms_d = bus.cmd_tms;
                    tdi_d = bus.cmd_tdi;
                    cap_d = '0;
                    idx_d = '0;
                    cnt_d = '0;
`ifdef JTAG_MASTER_TRST_EN
                    if (cmd_trst) begin
                        trstn_d   = 1'b0;
                        tms_pin_d = 1'b1;
                        state_d   = TRST;
                    end else
`endif
                    if (len_in == '0) begin
                        state_d = DONE;
                    end else begin
                        tms_pin_d = bus.cmd_tms[0];
                        tdi_pin_d = bus.cmd_tdi[0];
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (cnt_q == HALF_LAST) begin
                    tck_d        = 1'b1;
                    cap_d[idx_q] = TDO;
                    cnt_d        = '0;
                    state_d      = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    tck_d = 1'b0;
                    cnt_d = '0;
                    if ((LEN_W'(idx_q) + LEN_W'(1)) < len_q) begin
                        idx_d     = idx_next;
                        tms_pin_d = tms_q[idx_next];
                        tdi_pin_d = tdi_q[idx_next];
                        state_d   = LOW;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rsp_valid_d = 1'b1;
                rsp_tdo_d   = cap_q;
                state_d     = IDLE;
            end
`ifdef JTAG_MASTER_TRST_EN
            TRST: begin
                if (cnt_q == TRST_LAST) begin
                    trstn_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG driver that sits directly upstream of the on-chip TAP.
- Converts valid/ready command words into TCK/TMS/TDI bit sequences.
- Samples TDO for each bit and returns the captured bits as a response word.
- Used by on-chip BIST sequencers and simulation benches to drive the TAP. All TAP pins are generated from one system clock.

Parameters:
- CLK_DIV, 2, TCK half-period in CLK cycles (≥1); one TCK period = 2*CLK_DIV CLK cycles.
- MAX_BITS, 32, max bits per command; width of cmd_tms, cmd_tdi and rsp_tdo.
- LEN_W, $clog2(MAX_BITS+1), width of cmd_len.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RSTn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at CLK edge.
- cmd_len  input  LEN_W  number of bits to shift; values above MAX_BITS are clamped to MAX_BITS.
- cmd_tms  input  MAX_BITS  TMS per bit, bit 0 first.
- cmd_tdi  input  MAX_BITS  TDI per bit, bit 0 first.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_tdo  output  MAX_BITS  TDO captured per bit, bit 0 = first bit; bits ≥ len are 0.
- busy  output  1  high while shifting.
- TCK  output  1  test clock to TAP.
- TMS  output  1  test mode select to TAP.
- TDI  output  1  test data to TAP.
- TDO  input  1  test data from TAP; z/x is sampled as-is.

Behaviour:
- Reset (RSTn=0, async): TCK=0, TMS=1, TDI=0, rsp_valid=0, rsp_tdo=0, busy=0, state IDLE. TMS=1 keeps the TAP parked in Test-Logic-Reset.
- FSM states: IDLE, LOW, HIGH, DONE.
- cmd_ready = (state==IDLE) && !rsp_valid. Combinational; must not depend on cmd_valid.
- Accept edge: latch the clamped len, cmd_tms and cmd_tdi; clear the capture register and bit index.
  - If len==0: go to DONE.
  - Else: drive TMS=cmd_tms[0], TDI=cmd_tdi[0]; go to LOW.
- LOW: TCK=0 for CLK_DIV cycles. On the last-cycle edge, set TCK=1, capture TDO into bit[idx], go to HIGH. TDO is therefore sampled on the TCK rising edge, where the TAP-updated value has been stable since the prior falling edge.
- HIGH: TCK=1 for CLK_DIV cycles. On the last-cycle edge, set TCK=0, then:
  - If idx<len-1: idx+1, drive the next TMS/TDI on that same edge, go to LOW.
  - Else: go to DONE.
- DONE is a transient state: on the next edge, set rsp_valid=1, load rsp_tdo from the capture register, go to IDLE.
- Latency: rsp_valid rises exactly len*2*CLK_DIV+1 cycles after the accept edge. For len==0 it rises 1 cycle after accept, with no TCK pulses.
- TMS/TDI change only on CLK edges where TCK falls, or on the accept edge while TCK=0. They never change while TCK=1.
- After a command, TMS/TDI hold the last driven values; TCK stays 0.
- rsp_valid held with rsp_tdo stable until rsp_ready. It clears on the handshake edge; cmd_ready rises on that same edge.
- No new command is accepted while rsp_valid=1. Back-to-back throughput is therefore limited to one command per response handshake.
- busy = state in {LOW, HIGH, DONE}.
- Reset mid-shift: all outputs return to reset values immediately; partial capture is discarded and no response is produced.

Optional Feature:
- Macro JTAG_MASTER_TRST_EN.
- Defined:
  - Adds input cmd_trst (1) and output TRSTn (1); TRSTn resets to 1.
  - Accepted command with cmd_trst=1 ignores len/tms/tdi.
  - Drives TRSTn=0 for 2*CLK_DIV cycles with TCK=0 and TMS=1, then TRSTn=1.
  - Response with rsp_tdo=0, 2*CLK_DIV+1 cycles after accept.
- Undefined: ports absent; no TRST sequencing logic.

Test Plan:
- Reset, then check idle outputs: TCK=0, TMS=1, TDI=0, cmd_ready=1, rsp_valid=0. Assert RSTn mid-shift (len=32, bit 10) -> TCK=0 same cycle, no rsp_valid afterwards.
- CLK_DIV=2, len=5, tms=5'b11111 into TAP -> exactly 5 TCK pulses of period 4 CLK; rsp_valid at accept+21; TAP in Test-Logic-Reset, IR=IDCODE.
- After reset, shift TMS to Shift-DR (tms=4'b0010, len=4); then len=32, tdi=0, tms=0 -> rsp_tdo=32'hF00ED093 (DEVICE_ID).
- Load IR=4'b1111 (BYPASS), reach Shift-DR; shift len=8, tdi=8'hA5 -> rsp_tdo=8'h4A, i.e. one-bit bypass delay with leading capture 0.
- Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, rsp_tdo stable. Pulse rsp_ready -> next command accepted on the following edge. len=0 -> rsp_valid 1 cycle after accept, zero TCK edges.
- With JTAG_MASTER_TRST_EN and cmd_trst=1, CLK_DIV=2 -> TRSTn low exactly 4 cycles, TCK stays 0, TAP IR_outreg=IDCODE, rsp_tdo=0.
